// File: rtl/demux_dataflow_buffered.sv
// Receive-side 1:2 demultiplexer: steers shared stream C into lane A or B by S,
// each lane buffered by its own show-ahead FIFO with a valid/ready handshake.

module demux_dataflow_buffered_lane #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ready,
    output logic                     full,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             rd_en;

    // Fullness comes from the occupancy count, so pointer equality is never ambiguous.
    assign full  = (count_q == CW'(DEPTH));
    assign valid = (count_q != '0);
    assign rd_en = valid & rd_ready;
    assign head  = valid ? mem[rd_ptr] : '0;
    assign count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the lane is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end
endmodule

module demux_dataflow_buffered #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         C,
    input  logic                     S,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         A,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [WIDTH-1:0]         B,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [$clog2(DEPTH):0]   a_count,
    output logic [$clog2(DEPTH):0]   b_count
);
    logic a_full;
    logic b_full;
    logic a_wr;
    logic b_wr;

    // Ready reflects only the selected lane's fullness, independent of in_valid and consumers.
    assign in_ready = S ? ~b_full : ~a_full;
    assign a_wr     = in_valid & ~S & ~a_full;
    assign b_wr     = in_valid &  S & ~b_full;

    demux_dataflow_buffered_lane #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (a_wr),
        .wr_data  (C),
        .rd_ready (a_ready),
        .full     (a_full),
        .valid    (a_valid),
        .head     (A),
        .count    (a_count)
    );

    demux_dataflow_buffered_lane #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (b_wr),
        .wr_data  (C),
        .rd_ready (b_ready),
        .full     (b_full),
        .valid    (b_valid),
        .head     (B),
        .count    (b_count)
    );
endmodule

// File: tb/tb_demux_dataflow_buffered.sv
// Directed vector bench for demux_dataflow_buffered (WIDTH=2, DEPTH=2).

module tb_demux_dataflow_buffered;
    localparam int unsigned WIDTH = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned NV    = 30;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] C;
    logic             S;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] B;
    logic             b_valid;
    logic             b_ready;
    logic [CW-1:0]    a_count;
    logic [CW-1:0]    b_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             iv;
        logic             s;
        logic [WIDTH-1:0] c;
        logic             ar;
        logic             br;
        logic             e_rdy;
        logic [WIDTH-1:0] e_a;
        logic             e_av;
        logic [CW-1:0]    e_ac;
        logic [WIDTH-1:0] e_b;
        logic             e_bv;
        logic [CW-1:0]    e_bc;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    demux_dataflow_buffered #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .C        (C),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .B        (B),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    function automatic vec_t v(input logic iv, input logic s, input logic [WIDTH-1:0] c,
                               input logic ar, input logic br, input logic e_rdy,
                               input logic [WIDTH-1:0] e_a, input logic e_av, input logic [CW-1:0] e_ac,
                               input logic [WIDTH-1:0] e_b, input logic e_bv, input logic [CW-1:0] e_bc);
        vec_t r;
        r.iv = iv; r.s = s; r.c = c; r.ar = ar; r.br = br; r.e_rdy = e_rdy;
        r.e_a = e_a; r.e_av = e_av; r.e_ac = e_ac;
        r.e_b = e_b; r.e_bv = e_bv; r.e_bc = e_bc;
        return r;
    endfunction

    task automatic check_state(input string name, input logic [WIDTH-1:0] ea, input logic eav,
                               input logic [CW-1:0] eac, input logic [WIDTH-1:0] eb,
                               input logic ebv, input logic [CW-1:0] ebc);
        checks++;
        if ({A, a_valid, a_count, B, b_valid, b_count} !== {ea, eav, eac, eb, ebv, ebc}) begin
            errors++;
            $display("FAIL %s: got A=%0d av=%0d ac=%0d B=%0d bv=%0d bc=%0d, expected A=%0d av=%0d ac=%0d B=%0d bv=%0d bc=%0d",
                     name, A, a_valid, a_count, B, b_valid, b_count, ea, eav, eac, eb, ebv, ebc);
        end
    endtask

    task automatic check_rdy(input string name, input logic exp);
        checks++;
        if (in_ready !== exp) begin
            errors++;
            $display("FAIL %s: in_ready got %0d expected %0d", name, in_ready, exp);
        end
    endtask

    initial begin
        // Single steer
        vecs[0]  = v(1, 0, 2'd1, 0, 0, 1, 2'd1, 1, 2'd1, 2'd0, 0, 2'd0);
        vecs[1]  = v(1, 1, 2'd3, 0, 0, 1, 2'd1, 1, 2'd1, 2'd3, 1, 2'd1);
        vecs[2]  = v(0, 0, 2'd0, 1, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
        // Fill lane A, refuse third write
        vecs[3]  = v(1, 0, 2'd1, 0, 0, 1, 2'd1, 1, 2'd1, 2'd0, 0, 2'd0);
        vecs[4]  = v(1, 0, 2'd2, 0, 0, 1, 2'd1, 1, 2'd2, 2'd0, 0, 2'd0);
        vecs[5]  = v(1, 0, 2'd3, 0, 0, 0, 2'd1, 1, 2'd2, 2'd0, 0, 2'd0);
        vecs[6]  = v(0, 1, 2'd3, 0, 0, 1, 2'd1, 1, 2'd2, 2'd0, 0, 2'd0);
        // Full plus pop, then retry write
        vecs[7]  = v(1, 0, 2'd3, 1, 0, 0, 2'd2, 1, 2'd1, 2'd0, 0, 2'd0);
        vecs[8]  = v(1, 0, 2'd3, 0, 0, 1, 2'd2, 1, 2'd2, 2'd0, 0, 2'd0);
        vecs[9]  = v(0, 0, 2'd0, 1, 0, 0, 2'd3, 1, 2'd1, 2'd0, 0, 2'd0);
        vecs[10] = v(0, 0, 2'd0, 1, 0, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
        // Wrap and stream
        for (int i = 0; i < 8; i++) begin
            vecs[11+i] = v(1, 0, 2'(i), 1, 0, 1, 2'(i), 1, 2'd1, 2'd0, 0, 2'd0);
        end
        vecs[19] = v(0, 0, 2'd0, 1, 0, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
        // Cross-lane independence
        vecs[20] = v(1, 0, 2'd2, 1, 0, 1, 2'd2, 1, 2'd1, 2'd0, 0, 2'd0);
        vecs[21] = v(1, 1, 2'd3, 1, 0, 1, 2'd0, 0, 2'd0, 2'd3, 1, 2'd1);
        vecs[22] = v(1, 0, 2'd1, 1, 0, 1, 2'd1, 1, 2'd1, 2'd3, 1, 2'd1);
        vecs[23] = v(1, 1, 2'd0, 1, 0, 1, 2'd0, 0, 2'd0, 2'd3, 1, 2'd2);
        vecs[24] = v(1, 1, 2'd2, 1, 0, 0, 2'd0, 0, 2'd0, 2'd3, 1, 2'd2);
        vecs[25] = v(1, 0, 2'd1, 0, 0, 1, 2'd1, 1, 2'd1, 2'd3, 1, 2'd2);
        vecs[26] = v(1, 0, 2'd2, 1, 1, 1, 2'd2, 1, 2'd1, 2'd0, 1, 2'd1);
        vecs[27] = v(1, 1, 2'd1, 0, 1, 1, 2'd2, 1, 2'd1, 2'd1, 1, 2'd1);
        vecs[28] = v(0, 1, 2'd0, 1, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
        // Ready while empty
        vecs[29] = v(0, 0, 2'd0, 1, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);

        rst_n = 1'b0; in_valid = 1'b0; S = 1'b0; C = '0; a_ready = 1'b0; b_ready = 1'b0;
        #2;
        check_state("reset_initial", 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            in_valid = vecs[i].iv; S = vecs[i].s; C = vecs[i].c;
            a_ready = vecs[i].ar; b_ready = vecs[i].br;
            #1;
            check_rdy($sformatf("vec%0d_ready", i), vecs[i].e_rdy);
            @(posedge clk); #1;
            check_state($sformatf("vec%0d_state", i), vecs[i].e_a, vecs[i].e_av, vecs[i].e_ac,
                        vecs[i].e_b, vecs[i].e_bv, vecs[i].e_bc);
        end

        // Mid-stream reset: load both lanes, then reset between edges with in_valid held high
        in_valid = 1'b1; S = 1'b0; C = 2'd2; a_ready = 1'b0; b_ready = 1'b0;
        @(posedge clk); #1;
        S = 1'b1; C = 2'd1;
        @(posedge clk); #1;
        check_state("preload", 2'd2, 1, 2'd1, 2'd1, 1, 2'd1);
        rst_n = 1'b0;
        #1;
        check_state("reset_async", 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
        @(posedge clk); #1;
        check_state("reset_held", 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);
        rst_n = 1'b1; S = 1'b1; C = 2'd2;
        @(posedge clk); #1;
        check_state("post_reset_write", 2'd0, 0, 2'd0, 2'd2, 1, 2'd1);
        in_valid = 1'b0; b_ready = 1'b1;
        @(posedge clk); #1;
        check_state("post_reset_drain", 2'd0, 0, 2'd0, 2'd0, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_dataflow_buffered.md
Name: demux_dataflow_buffered

Overview:
- Inverse of the team's 2:1 data-path mux: takes a single selected stream C plus select S and steers each word back to lane A or lane B.
- Each lane has its own small FIFO with a valid/ready handshake, so the A and B consumers drain independently.
- Sits on the receive side wherever the mux output is carried over a shared path and must be split back into two channels.

Parameters:
- WIDTH, 2, data word width; matches the mux lane width.
- DEPTH, 2, entries per lane FIFO; power of two, >= 2.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- C  input  WIDTH  shared input data word.
- S  input  1  lane select for C: 0 = lane A, 1 = lane B (same encoding as the mux).
- in_valid  input  1  C/S valid this cycle.
- in_ready  output  1  the lane selected by S can accept a word.
- A  output  WIDTH  head word of lane A FIFO.
- a_valid  output  1  lane A FIFO non-empty.
- a_ready  input  1  lane A consumer accepts the head word.
- B  output  WIDTH  head word of lane B FIFO.
- b_valid  output  1  lane B FIFO non-empty.
- b_ready  input  1  lane B consumer accepts the head word.
- a_count  output  clog2(DEPTH)+1  lane A occupancy.
- b_count  output  clog2(DEPTH)+1  lane B occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): all pointers and counts go to 0; a_valid=b_valid=0; A=B=0; a_count=b_count=0. Takes effect immediately, regardless of clk.
- Reset mid-operation: all stored words are discarded. After release, the block starts empty; the first edge after release behaves normally.
- in_ready is combinational: S=0 -> !(a_count==DEPTH); S=1 -> !(b_count==DEPTH). It depends only on S and the selected lane's fullness, never on in_valid or on a_ready/b_ready.
- Write: in_valid & in_ready at an edge stores C at the tail of the selected lane. The other lane is untouched. A word is never written to both lanes.
- Write latency: a word written into an empty lane appears on A/B with valid high in the next cycle. There is no same-cycle bypass.
- Read: a_valid & a_ready at an edge pops lane A (same rule for B). A/B show the head word (show-ahead) and are forced to 0 when the lane is empty.
- Ready while not valid: a_ready/b_ready high with the lane empty has no effect.
- Simultaneous read and write, same lane, not full: both happen; count unchanged; order preserved.
- Simultaneous read and write, same lane, full: in_ready is already 0, so only the read happens; count drops by 1. in_ready rises combinationally in the following cycle.
- Writing one lane while popping the other: fully independent in the same cycle.
- Pointer wrap-around: pointers wrap modulo DEPTH. Full and empty are decided from the count, not from pointer equality.
- Counts: +1 on write-only, -1 on read-only, range 0..DEPTH, never wrap.
- in_valid low: S and C are don't-care; no state change.
- FIFO order: strict per lane. There is no ordering guarantee between lanes.

Test Plan:
- Reset with in_valid=1 held low-active mid-stream -> a_valid=b_valid=0, A=B=0, counts 0 immediately, before any clk edge.
- Single steer, a_ready=b_ready=0: S=0,C=1 one cycle, then S=1,C=3 one cycle -> next cycles A=1,a_valid=1,a_count=1 and B=3,b_valid=1,b_count=1.
- Fill lane A, DEPTH=2, a_ready=0: S=0, C=1 then C=2 -> a_count=2, in_ready=0 for S=0 and 1 for S=1. A third write of C=3 is refused; lane A still pops 1 then 2.
- Full plus pop: lane A full with {1,2}, a_ready=1 with in_valid=1,S=0,C=3 -> only the pop occurs, count=1. Next cycle the write of 3 succeeds; pops yield 2 then 3.
- Wrap and stream: S=0, C=0,1,2,3,0,1,2,3 with a_ready=1 every cycle -> A shows 0,1,2,3,0,1,2,3, each one cycle after its write. a_count stays 1 in steady state with no loss; pointers wrap at least twice.
- Cross-lane independence: alternate S=0/1 with C=2,3,1,0 while b_ready=0 and a_ready=1 -> lane A drains 2,1; lane B holds 3,0 with b_count=2. in_ready drops only when S=1.
